// File: rtl/mac_seq_ctrl_if.sv
// rtl/mac_seq_ctrl_if.sv - job, operand-stream, MAC and result signals of the MAC sequencing controller
interface mac_seq_ctrl_if #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 2 * IN_BITWIDTH,
  parameter int LEN_BITS     = 8
);
  logic                    start;
  logic [LEN_BITS-1:0]     cfg_len;
  logic [IN_BITWIDTH-1:0]  psum_in;
  logic                    in_valid;
  logic                    in_ready;
  logic [IN_BITWIDTH-1:0]  act_data;
  logic [IN_BITWIDTH-1:0]  wgt_data;
  logic [IN_BITWIDTH-1:0]  mac_a;
  logic [IN_BITWIDTH-1:0]  mac_w;
  logic [IN_BITWIDTH-1:0]  mac_sum;
  logic [OUT_BITWIDTH-1:0] mac_out;
  logic                    out_valid;
  logic                    out_ready;
  logic [IN_BITWIDTH-1:0]  psum_out;
  logic                    overflow;
  logic                    busy;
  logic                    done;

  // The controller side; it also drives the operands of the external combinational MAC.
  modport slave (
    input  start, cfg_len, psum_in, in_valid, act_data, wgt_data, mac_out, out_ready,
    output in_ready, mac_a, mac_w, mac_sum, out_valid, psum_out, overflow, busy, done
  );

  modport master (
    output start, cfg_len, psum_in, in_valid, act_data, wgt_data, mac_out, out_ready,
    input  in_ready, mac_a, mac_w, mac_sum, out_valid, psum_out, overflow, busy, done
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// rtl/mac_seq_ctrl.sv - sequences len act/wgt pairs through an external MAC into one partial sum
module mac_seq_ctrl #(
  parameter int IN_BITWIDTH  = 16,
  parameter int OUT_BITWIDTH = 2 * IN_BITWIDTH,
  parameter int LEN_BITS     = 8
) (
  input  logic          clk,
  input  logic          reset,
  mac_seq_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t                 state_q, state_d;
  logic [IN_BITWIDTH-1:0] acc_q, acc_d;
  logic [LEN_BITS-1:0]    count_q, count_d;
  logic [LEN_BITS-1:0]    len_q, len_d;
  logic                   ovf_q, ovf_d;

  logic                   in_ready_c;
  logic                   out_valid_c;
  logic                   done_c;
  logic                   mac_hi_nz;
  logic                   last_pair;

  assign mac_hi_nz = |bus.mac_out[OUT_BITWIDTH-1:IN_BITWIDTH];
  assign last_pair = (count_q == (len_q - LEN_BITS'(1)));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      acc_q   <= '0;
      count_q <= '0;
      len_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      count_q <= count_d;
      len_q   <= len_d;
      ovf_q   <= ovf_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    acc_d       = acc_q;
    count_d     = count_q;
    len_d       = len_q;
    ovf_d       = ovf_q;
    in_ready_c  = 1'b0;
    out_valid_c = 1'b0;
    done_c      = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          acc_d   = bus.psum_in;
          ovf_d   = 1'b0;
          count_d = '0;
          // A zero-length job has nothing to accumulate and presents psum_in directly.
          if (bus.cfg_len != '0) begin
            len_d   = bus.cfg_len;
            state_d = ACCUM;
          end else begin
            state_d = DRAIN;
          end
        end
      end

      ACCUM: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
          acc_d   = bus.mac_out[IN_BITWIDTH-1:0];
          count_d = count_q + LEN_BITS'(1);
          if (mac_hi_nz) begin
            ovf_d = 1'b1;
          end
          if (last_pair) begin
            state_d = DRAIN;
          end
        end
      end

      DRAIN: begin
        out_valid_c = 1'b1;
        if (bus.out_ready) begin
          done_c  = 1'b1;
          state_d = IDLE;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.out_valid = out_valid_c;
  assign bus.done      = done_c;
  assign bus.busy      = (state_q != IDLE);
  assign bus.psum_out  = acc_q;
  assign bus.overflow  = ovf_q;
  assign bus.mac_a     = bus.act_data;
  assign bus.mac_w     = bus.wgt_data;
  assign bus.mac_sum   = acc_q;

endmodule

// File: tb/tb_mac_seq_ctrl.sv
// tb/tb_mac_seq_ctrl.sv - directed and randomized checks of mac_seq_ctrl against a job-level model
module tb_mac_seq_ctrl;
  localparam int IW = 16;
  localparam int OW = 32;
  localparam int LB = 8;
  localparam longint MASK = (longint'(1) << IW) - 1;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  mac_seq_ctrl_if #(.IN_BITWIDTH(IW), .OUT_BITWIDTH(OW), .LEN_BITS(LB)) bus ();

  assign bus.mac_out = OW'(bus.mac_a) * OW'(bus.mac_w) + OW'(bus.mac_sum);

  mac_seq_ctrl #(.IN_BITWIDTH(IW), .OUT_BITWIDTH(OW), .LEN_BITS(LB)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d t=%0t", name, act, exp, $time);
    end
  endtask

  // Job-level model: pairs still owed, running sum modulo 2^IW, sticky overflow.
  bit     m_accum = 1'b0;
  bit     m_drain = 1'b0;
  bit     m_ovf   = 1'b0;
  int     m_rem   = 0;
  longint m_acc   = 0;
  longint m_full  = 0;
  int     m_jobs  = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      m_accum = 1'b0;
      m_drain = 1'b0;
      m_ovf   = 1'b0;
      m_rem   = 0;
      m_acc   = 0;
    end else if (m_drain) begin
      if (bus.out_ready) begin
        m_drain = 1'b0;
        m_jobs++;
      end
    end else if (m_accum) begin
      if (bus.in_valid) begin
        m_full = longint'(bus.act_data) * longint'(bus.wgt_data) + m_acc;
        if (m_full > MASK) m_ovf = 1'b1;
        m_acc = m_full & MASK;
        m_rem--;
        if (m_rem == 0) begin
          m_accum = 1'b0;
          m_drain = 1'b1;
        end
      end
    end else if (bus.start) begin
      m_acc = longint'(bus.psum_in);
      m_ovf = 1'b0;
      m_rem = int'(bus.cfg_len);
      if (m_rem == 0) m_drain = 1'b1;
      else            m_accum = 1'b1;
    end
  end

  always @(negedge clk) begin
    chk("in_ready",  bus.in_ready,  longint'(m_accum));
    chk("out_valid", bus.out_valid, longint'(m_drain));
    chk("busy",      bus.busy,      longint'(m_accum | m_drain));
    chk("done",      bus.done,      longint'(m_drain && bus.out_ready));
    chk("psum_out",  bus.psum_out,  m_acc);
    chk("overflow",  bus.overflow,  longint'(m_ovf));
    chk("mac_sum",   bus.mac_sum,   m_acc);
    chk("mac_a",     bus.mac_a,     longint'(bus.act_data));
    chk("mac_w",     bus.mac_w,     longint'(bus.wgt_data));
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic start_job(input int len, input int psum);
    bus.start   = 1'b1;
    bus.cfg_len = LB'(len);
    bus.psum_in = IW'(psum);
    step();
    bus.start = 1'b0;
  endtask

  task automatic pair(input int a, input int w);
    bus.in_valid = 1'b1;
    bus.act_data = IW'(a);
    bus.wgt_data = IW'(w);
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    bus.out_ready = 1'b1;
    #1;
    chk({tag, "_done"}, bus.done, 1);
    step();
    bus.out_ready = 1'b0;
    chk({tag, "_idle_valid"}, bus.out_valid, 0);
    chk({tag, "_idle_busy"}, bus.busy, 0);
  endtask

  initial begin
    bus.start = 1'b0; bus.cfg_len = '0; bus.psum_in = '0;
    bus.in_valid = 1'b0; bus.act_data = '0; bus.wgt_data = '0;
    bus.out_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_psum", bus.psum_out, 0);
    chk("rst_busy", bus.busy, 0);
    reset = 1'b0;
    step();

    start_job(3, 0);
    chk("j1_in_ready", bus.in_ready, 1);
    pair(15, 0);
    pair(1, 61000);
    pair(2, 12000);
    chk("j1_valid", bus.out_valid, 1);
    chk("j1_psum", bus.psum_out, 19464);
    chk("j1_ovf", bus.overflow, 1);
    drain("j1");

    start_job(1, 4000);
    pair(1, 61000);
    chk("j2_psum", bus.psum_out, 65000);
    chk("j2_ovf", bus.overflow, 0);
    chk("j2_no_done", bus.done, 0);
    drain("j2");

    start_job(1, 17000);
    for (int i = 0; i < 3; i++) begin
      chk("j3_ready_held", bus.in_ready, 1);
      chk("j3_psum_wait", bus.psum_out, 17000);
      step();
    end
    pair(500, 50);
    chk("j3_psum", bus.psum_out, 42000);
    chk("j3_valid", bus.out_valid, 1);
    drain("j3");

    start_job(0, 1234);
    chk("j4_valid", bus.out_valid, 1);
    chk("j4_psum", bus.psum_out, 1234);
    chk("j4_no_ready", bus.in_ready, 0);
    drain("j4");

    start_job(1, 100);
    pair(2, 3);
    for (int i = 0; i < 5; i++) begin
      chk("j5_stable", bus.psum_out, 106);
      chk("j5_no_done", bus.done, 0);
      chk("j5_valid", bus.out_valid, 1);
      if (i == 2) begin
        bus.start = 1'b1; bus.cfg_len = LB'(2); bus.psum_in = IW'(9);
      end
      step();
      bus.start = 1'b0;
    end
    drain("j5");
    chk("j5_after_psum", bus.psum_out, 106);

    start_job(4, 7);
    pair(1, 1);
    pair(1, 1);
    chk("j6_mid_busy", bus.busy, 1);
    reset = 1'b1;
    #1;
    chk("j6_rst_ready", bus.in_ready, 0);
    chk("j6_rst_busy", bus.busy, 0);
    chk("j6_rst_psum", bus.psum_out, 0);
    chk("j6_rst_valid", bus.out_valid, 0);
    step();
    reset = 1'b0;
    start_job(2, 5);
    pair(1, 1);
    pair(2, 2);
    chk("j7_psum", bus.psum_out, 10);
    chk("j7_ovf", bus.overflow, 0);
    chk("j7_valid", bus.out_valid, 1);
    drain("j7");

    for (int c = 0; c < 4000; c++) begin
      bus.start     = ($urandom % 3) == 0;
      bus.cfg_len   = LB'($urandom % 6);
      bus.psum_in   = IW'($urandom);
      bus.in_valid  = ($urandom % 4) != 0;
      bus.act_data  = (($urandom % 2) == 0) ? IW'($urandom % 256) : IW'($urandom);
      bus.wgt_data  = (($urandom % 2) == 0) ? IW'($urandom % 256) : IW'($urandom);
      bus.out_ready = ($urandom % 3) != 0;
      reset         = ($urandom % 250) == 0;
      step();
    end
    reset = 1'b0;
    bus.start = 1'b0; bus.in_valid = 1'b0; bus.out_ready = 1'b0;
    step();
    chk("random_jobs_completed", longint'(m_jobs > 100), 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
